// File: rtl/data_memory_pkg.sv
// Shared definitions for the data-memory stage: store-length codes and
// default array geometry.
package dm_defs;

   typedef enum logic [1:0] {
      WLEN_WORD = 2'b00,
      WLEN_HALF = 2'b01,
      WLEN_BYTE = 2'b10,
      WLEN_RSVD = 2'b11
   } wlen_e;

   localparam int DM_ADDR_WORDS = 1024;
   localparam int DM_AW         = 10;

endpackage

// File: rtl/data_memory_if.sv
// Core <-> data-memory bus. The core drives address/store signals and reads
// back the combinational word plus the store-trace record.
interface data_memory_if;
   import dm_defs::*;

   logic [31:0] PC;
   logic [31:0] DMAdr;
   logic        DMWE;
   logic [31:0] DMDataW;
   logic [1:0]  DMWLen;
   logic [31:0] DMDataR;
   logic        AlignErr;
   logic        LastWValid;
   logic [31:0] LastWPC;
   logic [31:0] LastWAdr;
   logic [31:0] LastWData;

   modport master (
      output PC, DMAdr, DMWE, DMDataW, DMWLen,
      input  DMDataR, AlignErr, LastWValid, LastWPC, LastWAdr, LastWData
   );

   modport slave (
      input  PC, DMAdr, DMWE, DMDataW, DMWLen,
      output DMDataR, AlignErr, LastWValid, LastWPC, LastWAdr, LastWData
   );

endinterface

// File: rtl/dm_store_merge.sv
// Byte-lane store merge: overlays the right-aligned store payload onto the
// old word for the selected lanes and reports whether the store is aligned.
module dm_store_merge
   import dm_defs::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  wlen,
   input  logic [1:0]  lane,
   output logic [31:0] merged,
   output logic        legal
);

   for (genvar k = 0; k < 4; k++) begin : g_lane
      localparam logic [1:0] LK = 2'(k);
      logic [7:0] b;

      // pick new payload byte for this lane if the store covers it, else keep old
      always_comb begin
         b = old_word[8*k +: 8];
         unique case (wlen_e'(wlen))
            WLEN_WORD: b = wdata[8*k +: 8];
            WLEN_HALF: if (LK[1] == lane[1]) b = wdata[8*(k%2) +: 8];
            WLEN_BYTE: if (LK == lane)       b = wdata[7:0];
            default:   b = old_word[8*k +: 8];
         endcase
      end

      assign merged[8*k +: 8] = b;
   end

   // natural alignment; reserved length is never legal
   always_comb begin
      legal = 1'b0;
      unique case (wlen_e'(wlen))
         WLEN_WORD: legal = (lane == 2'b00);
         WLEN_HALF: legal = ~lane[0];
         WLEN_BYTE: legal = 1'b1;
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with byte-lane store merging, sticky alignment
// error flag and a registered record of the last committed store.
module data_memory
   import dm_defs::*;
#(
   parameter int ADDR_WORDS = DM_ADDR_WORDS,
   parameter int AW         = DM_AW
) (
   input  logic         clk,
   input  logic         reset,
   data_memory_if.slave bus
);

   logic [31:0]   mem [ADDR_WORDS];
   logic [AW-1:0] idx;
   logic [31:0]   old_word;
   logic [31:0]   merged;
   logic          legal;
   logic          commit;

   // upper address bits are ignored, so addresses alias modulo the array size
   assign idx      = bus.DMAdr[AW+1:2];
   assign old_word = mem[idx];
   assign bus.DMDataR = old_word;
   assign commit   = bus.DMWE & legal;

   dm_store_merge u_merge (
      .old_word (old_word),
      .wdata    (bus.DMDataW),
      .wlen     (bus.DMWLen),
      .lane     (bus.DMAdr[1:0]),
      .merged   (merged),
      .legal    (legal)
   );

   // array: cleared on reset, otherwise takes the merged word on a legal store
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ADDR_WORDS; i++) mem[i] <= '0;
      end else if (commit) begin
         mem[idx] <= merged;
      end
   end

   // store-trace record and sticky misalignment flag
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.AlignErr   <= 1'b0;
         bus.LastWValid <= 1'b0;
         bus.LastWPC    <= '0;
         bus.LastWAdr   <= '0;
         bus.LastWData  <= '0;
      end else begin
         bus.LastWValid <= commit;
         if (commit) begin
            bus.LastWPC   <= bus.PC;
            bus.LastWAdr  <= {bus.DMAdr[31:2], 2'b00};
            bus.LastWData <= merged;
         end
         if (bus.DMWE && !legal) bus.AlignErr <= 1'b1;
      end
   end

endmodule
